// File: rtl/spi_device_pkg.sv
// spi_device_pkg: shared types and constants for the SPI mode-0 device
// responder and its synchronizer.
package spi_device_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LAST  = 2'd2
    } spi_state_e;

    localparam int DataWidthDef = 8;
    localparam int BitCntWidth  = $clog2(DataWidthDef + 1);

endpackage

// File: rtl/spi_device_sync.sv
// spi_device_sync: multi-flop synchronizer for sck/sdi with registered
// sck history for rise/fall detection in the system clock domain.
module spi_device_sync
    import spi_device_pkg::*;
#(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sck_i,
    input  logic sdi_i,
    output logic sdi_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncStages-1:0] sck_q;
    logic [SyncStages-1:0] sdi_q;
    logic                  sck_prev_q;
    logic                  sck_s;

    assign sck_s  = sck_q[SyncStages-1];
    assign sdi_o  = sdi_q[SyncStages-1];
    assign rise_o = sck_s & ~sck_prev_q;
    assign fall_o = ~sck_s & sck_prev_q;

    // Shift both lines through the synchronizer and remember last sck.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q      <= '0;
            sdi_q      <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= {sck_q[SyncStages-2:0], sck_i};
            sdi_q      <= {sdi_q[SyncStages-2:0], sdi_i};
            sck_prev_q <= sck_s;
        end
    end

endmodule

// File: rtl/spi_device_resp.sv
// spi_device_resp: chip-select-less SPI mode-0 responder, framed by bit
// count with an idle-timeout resync; rx stream out, one-entry tx holding.
module spi_device_resp
    import spi_device_pkg::*;
#(
    parameter int DataWidth   = 8,
    parameter int SyncStages  = 2,
    parameter int IdleTimeout = 64
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic                 spi_sck_i,
    input  logic                 spi_sdi_i,
    output logic                 spi_sdo_o,
    output logic [DataWidth-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    input  logic [DataWidth-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 rx_overflow_o,
    output logic                 tx_underrun_o,
    output logic                 frame_abort_o,
    output logic                 busy_o
);

    localparam int CntW = $clog2(DataWidth + 1);
    localparam int TmrW = $clog2(IdleTimeout + 1);

    logic sdi_s;
    logic rise;
    logic fall;

    spi_device_sync #(
        .SyncStages(SyncStages)
    ) u_sync (
        .clk_i (clk_sys_i),
        .rst_i (rst_sys_i),
        .sck_i (spi_sck_i),
        .sdi_i (spi_sdi_i),
        .sdi_o (sdi_s),
        .rise_o(rise),
        .fall_o(fall)
    );

    spi_state_e           state_q;
    logic [CntW-1:0]      bit_cnt_q;
    logic [TmrW-1:0]      timer_q;
    logic [TmrW-1:0]      timer_d;
    logic [DataWidth-2:0] shift_rx_q;
    logic [DataWidth-1:0] rx_byte;
    logic [DataWidth-1:0] shift_tx_q;
    logic [DataWidth-1:0] hold_q;
    logic                 hold_valid_q;
    logic                 loaded_q;
    logic [DataWidth-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_overflow_q;
    logic                 tx_underrun_q;
    logic                 abort_q;
    logic                 timeout;

    // The final bit goes straight into rx_data, so only DataWidth-1 are kept.
    assign rx_byte = {shift_rx_q, sdi_s};
    assign timer_d = timer_q + 1'b1;
    assign timeout = (state_q != ST_IDLE) && !rise && !fall
                     && (timer_d == TmrW'(IdleTimeout));

    assign spi_sdo_o     = shift_tx_q[DataWidth-1];
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_ready_o    = ~hold_valid_q;
    assign rx_overflow_o = rx_overflow_q;
    assign tx_underrun_o = tx_underrun_q;
    assign frame_abort_o = abort_q;
    assign busy_o        = (state_q != ST_IDLE);

    // Frame FSM with tx holding register, rx delivery and sticky flags.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            timer_q       <= '0;
            shift_rx_q    <= '0;
            shift_tx_q    <= '0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            loaded_q      <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overflow_q <= 1'b0;
            tx_underrun_q <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
            if (tx_valid_i && !hold_valid_q) begin
                hold_q       <= tx_data_i;
                hold_valid_q <= 1'b1;
            end
            if (timeout) begin
                state_q    <= ST_IDLE;
                bit_cnt_q  <= '0;
                timer_q    <= '0;
                shift_rx_q <= '0;
                loaded_q   <= 1'b0;
                abort_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        timer_q <= '0;
                        if (rise) begin
                            // A load in this same cycle loses: unloaded.
                            shift_rx_q <= rx_byte[DataWidth-2:0];
                            bit_cnt_q  <= CntW'(1);
                            state_q    <= ST_SHIFT;
                            if (!loaded_q) begin
                                tx_underrun_q <= 1'b1;
                                shift_tx_q    <= '0;
                            end
                        end else if (hold_valid_q && !loaded_q) begin
                            shift_tx_q   <= hold_q;
                            hold_valid_q <= 1'b0;
                            loaded_q     <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        timer_q <= (rise || fall) ? '0 : timer_d;
                        if (fall) begin
                            shift_tx_q <= {shift_tx_q[DataWidth-2:0], 1'b0};
                        end
                        if (rise) begin
                            shift_rx_q <= rx_byte[DataWidth-2:0];
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == CntW'(DataWidth - 1)) begin
                                state_q <= ST_LAST;
                                if (!rx_valid_q || rx_ready_i) begin
                                    rx_data_q  <= rx_byte;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    rx_overflow_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_LAST: begin
                        timer_q <= (rise || fall) ? '0 : timer_d;
                        if (fall) begin
                            state_q   <= ST_IDLE;
                            loaded_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            timer_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_device_resp.sv
// tb_spi_device_resp: directed bench for spi_device_resp acting as the
// SPI host (half-period 4 clk_sys cycles) with hand-computed expectations.
module tb_spi_device_resp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic       sdo;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ovf;
    logic       und;
    logic       abort;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    spi_device_resp dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .spi_sck_i    (sck),
        .spi_sdi_i    (sdi),
        .spi_sdo_o    (sdo),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_overflow_o(ovf),
        .tx_underrun_o(und),
        .frame_abort_o(abort),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) hs_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_sdo"}, 32'(sdo), 0);
        chk({p, "_rxdata"}, 32'(rx_data), 0);
        chk({p, "_rxvalid"}, 32'(rx_valid), 0);
        chk({p, "_txready"}, 32'(tx_ready), 1);
        chk({p, "_ovf"}, 32'(ovf), 0);
        chk({p, "_und"}, 32'(und), 0);
        chk({p, "_abort"}, 32'(abort), 0);
        chk({p, "_busy"}, 32'(busy), 0);
    endtask

    // Host side: drive n MSB-first bits, sample sdo just before each rise.
    // ack_last pulses rx_ready on the cycle the DUT completes the byte.
    task automatic send_bits(input int n, input logic [7:0] mosi,
                             input bit ack_last, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < n; i++) begin
            sdi = mosi[7-i];
            repeat (4) @(negedge clk);
            miso = {miso[6:0], sdo};
            sck = 1'b1;
            if (ack_last && i == n - 1) begin
                repeat (2) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            sck = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] b2b_miso [3];
        int         n_abort;
        int         n_valid;
        int         hs0;

        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;

        // loopback: A5 preloaded, host sends 3C
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("lb_hold_full", 32'(tx_ready), 0);
        @(negedge clk);
        chk("lb_hold_empty", 32'(tx_ready), 1);
        send_bits(8, 8'h3C, 1'b0, m);
        chk("lb_miso", 32'(m), 32'hA5);
        chk("lb_rxvalid", 32'(rx_valid), 1);
        chk("lb_rxdata", 32'(rx_data), 32'h3C);
        chk("lb_ovf", 32'(ovf), 0);
        chk("lb_und", 32'(und), 0);
        repeat (4) @(negedge clk);
        chk("lb_idle", 32'(busy), 0);

        // underrun after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_bits(8, 8'hFF, 1'b0, m);
        chk("ur_miso", 32'(m), 32'h00);
        chk("ur_flag", 32'(und), 1);
        chk("ur_rxdata", 32'(rx_data), 32'hFF);

        // overflow
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("ov_drain", 32'(rx_valid), 0);
        send_bits(8, 8'h11, 1'b0, m);
        chk("ov_first", 32'(rx_data), 32'h11);
        chk("ov_noflag", 32'(ovf), 0);
        send_bits(8, 8'h22, 1'b0, m);
        chk("ov_kept", 32'(rx_data), 32'h11);
        chk("ov_flag", 32'(ovf), 1);
        send_bits(8, 8'h33, 1'b1, m);
        chk("ov_third", 32'(rx_data), 32'h33);
        chk("ov_third_vld", 32'(rx_valid), 1);

        // timeout abort after 3 bits
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        send_bits(3, 8'hE0, 1'b0, m);
        chk("to_busy", 32'(busy), 1);
        n_abort = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (abort) n_abort++;
        end
        chk("to_pulses", 32'(n_abort), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_norx", 32'(rx_valid), 0);
        send_bits(8, 8'h5A, 1'b0, m);
        chk("to_resync", 32'(rx_data), 32'h5A);
        chk("to_resync_vld", 32'(rx_valid), 1);

        // reset mid-frame
        send_bits(5, 8'hFF, 1'b0, m);
        chk("mr_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("mr");
        rst = 1'b0;
        n_abort = 0;
        n_valid = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (abort) n_abort++;
            if (rx_valid) n_valid++;
        end
        chk("mr_noabort", 32'(n_abort), 0);
        chk("mr_norx", 32'(n_valid), 0);
        send_bits(8, 8'hC3, 1'b0, m);
        chk("mr_next", 32'(rx_data), 32'hC3);

        // back-to-back frames with tx_valid held
        rx_ready = 1'b1;
        hs0 = hs_cnt;
        fork
            begin
                int wn;
                for (int k = 1; k <= 3; k++) begin
                    tx_data  = 8'(k);
                    tx_valid = 1'b1;
                    wn = 0;
                    while (!tx_ready && wn < 2000) begin
                        @(negedge clk);
                        wn++;
                    end
                    @(negedge clk);
                end
                tx_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    send_bits(8, 8'hF0 | 8'(k), 1'b0, m);
                    b2b_miso[k] = m;
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("bb_miso0", 32'(b2b_miso[0]), 32'h01);
        chk("bb_miso1", 32'(b2b_miso[1]), 32'h02);
        chk("bb_miso2", 32'(b2b_miso[2]), 32'h03);
        chk("bb_hs", 32'(hs_cnt - hs0), 3);
        chk("bb_rxdata", 32'(rx_data), 32'hF2);
        rx_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_device_resp.md
Name: spi_device_resp

Overview:
- SPI mode-0 responder (device) for the demo system's SPI host port: receives on the host's sck/tx lines and drives the host's rx line.
- Serves as an on-FPGA loopback/peripheral model in board top levels and as a bench responder in simulation.
- Oversamples sck in the system clock domain. No chip select exists on the link, so bytes are framed by bit count, with an idle-timeout resync.
- Presents received bytes as a valid/ready stream and accepts transmit bytes through a one-entry valid/ready holding register.

Parameters:
- DataWidth, 8, bits per SPI frame; MSB first.
- SyncStages, 2, synchronizer flops on spi_sck_i and spi_sdi_i (minimum 2).
- IdleTimeout, 64, clk_sys cycles with no sck edge mid-frame before the frame is aborted.

Ports:
- clk_sys_i  in  1  system clock.
- rst_sys_i  in  1  synchronous, active-high reset.
- spi_sck_i  in  1  serial clock from host; idles low (CPOL=0).
- spi_sdi_i  in  1  host-to-device data.
- spi_sdo_o  out  1  device-to-host data.
- rx_data_o  out  DataWidth  received byte.
- rx_valid_o  out  1  rx_data_o valid; held until accepted.
- rx_ready_i  in  1  consumer accepts rx byte.
- tx_data_i  in  DataWidth  byte to send in the next frame.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  holding register empty.
- rx_overflow_o  out  1  sticky: received byte dropped.
- tx_underrun_o  out  1  sticky: frame started with nothing loaded.
- frame_abort_o  out  1  one-cycle pulse on timeout abort.
- busy_o  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset (synchronous, rst_sys_i=1 on a clk_sys_i edge):
  - All outputs 0, except tx_ready_o=1.
  - Synchronizers, shift registers, bit counter and timer cleared; state=IDLE.
  - Reset mid-frame abandons the frame silently: no abort pulse, no rx byte.
- Sync and edge detection:
  - sck and sdi each pass through SyncStages flops.
  - rise = synced sck & ~previous synced sck; fall = ~synced & previous.
  - Host constraint: sck half-period >= SyncStages+2 clk_sys cycles.
  - Edge detect latency is SyncStages+1 cycles.
- TX holding register: 1 entry; tx_ready_o = ~hold_valid; accepted when tx_valid_i & tx_ready_o.
- State IDLE (bit_cnt=0):
  - If hold_valid & ~loaded: shift_tx <= hold, hold_valid <= 0, loaded <= 1. This takes one cycle, and spi_sdo_o = shift_tx MSB before the first rise.
  - On rise: sample sdi into shift_rx LSB, bit_cnt <= 1, go to SHIFT.
  - If the rise occurs with loaded=0: tx_underrun_o <= 1 and shift_tx = all-zeros fill.
  - The same-cycle load-and-rise case uses the old (unloaded) state → underrun.
- State SHIFT:
  - On fall: shift_tx left by 1, zero fill; spi_sdo_o follows the new MSB.
  - On rise: sample sdi, bit_cnt++.
  - On the rise where bit_cnt reaches DataWidth: byte complete, go to LAST.
- State LAST:
  - On fall: go to IDLE, loaded <= 0, bit_cnt <= 0, spi_sdo_o unchanged until the next load.
- Byte completion (rx delivery):
  - If ~rx_valid_o, or rx_ready_i in the same cycle: rx_data_o <= shift_rx, rx_valid_o <= 1 on the next cycle.
  - Else rx_overflow_o <= 1, the new byte is dropped and the old byte is kept.
  - rx_valid_o clears on rx_ready_i when no new byte arrives.
- Timeout:
  - In SHIFT/LAST, a counter resets on any edge.
  - On reaching IdleTimeout: state=IDLE, bit_cnt=0, partial rx discarded, loaded <= 0 (loaded tx byte discarded), frame_abort_o pulses one cycle.
- Sticky flags clear only on reset.
- rise and fall in the same cycle are impossible by construction.

Decomposition:
- spi_device_pkg:
  - state enum (IDLE, SHIFT, LAST) as a 2-bit logic enum.
  - Localparam for bit-counter width = $clog2(DataWidth+1).
- Sub-module spi_device_sync:
  - Parameterised SyncStages synchronizer for sck/sdi plus rise/fall edge detection.
  - Reused by a future SPI host-side sampler.

Test Plan:
- Loopback byte:
  - Stimulus: tx_data_i=0xA5 preloaded; host clocks 0x3C at sck half-period 4 cycles.
  - Response: host samples 0xA5 on sdo; rx_valid_o with rx_data_o=0x3C; flags 0.
- Underrun:
  - Stimulus: no tx loaded; host clocks 0xFF.
  - Response: host reads 0x00; tx_underrun_o=1; rx_data_o=0xFF.
- Overflow:
  - Stimulus: rx_ready_i=0; host sends 0x11 then 0x22.
  - Response: rx_data_o stays 0x11; rx_overflow_o=1.
  - Follow-up: assert rx_ready_i at the completion cycle of the third byte 0x33 → 0x33 delivered, no new overflow.
- Timeout abort:
  - Stimulus: host sends 3 bits then stops 64 cycles.
  - Response: frame_abort_o pulses once; busy_o→0.
  - Follow-up: next full byte 0x5A received correctly, aligned.
- Reset mid-frame:
  - Stimulus: assert rst_sys_i after 5 bits.
  - Response: all outputs at reset values next cycle; tx_ready_o=1; no rx byte or abort.
  - Follow-up: next frame 0xC3 received correctly.
- Back-to-back:
  - Stimulus: tx stream 0x01,0x02,0x03 with tx_valid_i held; host sends 3 frames with minimum inter-frame gap.
  - Response: host reads 0x01,0x02,0x03; tx_ready_o handshakes occur exactly 3 times.
